halflife_sequencer: RTL
=======================

# halflife_sequencer

Control sequencer for the 4-bit half-life counter. It loads an initial activity value, then at a programmable period replaces the counter value with half of itself. When the value decays to zero it reports completion. It sits between the user-facing start/config inputs and the counter's rst/up/down/load/in control pins, and is the only block that drives those pins.

## Interface
- N, 4, counter width; must match the counter instance.
- PW, 8, width of the period prescaler.

- clk  in  1  system clock; every flop is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin a decay run. Honoured only in IDLE.
- init_val  in  N  initial count, sampled on the cycle start is accepted.
- period  in  PW  number of RUN cycles per half-life, sampled on start acceptance. A value of 0 is treated as 1.
- cnt_q  in  N  current counter output (feedback).
- cnt_rst  out  1  synchronous clear request to the counter.
- cnt_up  out  1  increment request; always 0.
- cnt_down  out  1  decrement request; used only in linear mode.
- cnt_load  out  1  load request.
- cnt_d  out  N  load data for the counter.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- halvings  out  4  number of half-lives elapsed in the current run; saturates at 15.

## Operation
- States: IDLE, LOAD, RUN, STEP, DONE. Binary encoded.
- At most one of cnt_rst, cnt_down, cnt_load may be high in any cycle. cnt_d is 0 whenever cnt_load is low.
- IDLE: all counter controls are 0.
  - On start=1: latch init_val and period (0 becomes 1).
  - Clear halvings and the prescaler.
  - Go to LOAD.
- LOAD: drive cnt_load=1 with cnt_d=latched init_val.
  - If the latched value is 0, go to DONE.
  - Otherwise go to RUN.
- RUN: the prescaler counts from 0 to period-1, one count per cycle.
  - At period-1, clear the prescaler and go to STEP.
- STEP (halving mode): drive cnt_load=1 with cnt_d = cnt_q >> 1 (logical shift; the MSB is filled with 0).
  - Increment halvings, saturating at 15.
  - If cnt_q >> 1 is 0, go to DONE. Otherwise go to RUN.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - halvings holds its value until the next accepted start.
- start is ignored in every state except IDLE. A start held high in DONE is accepted in the following IDLE cycle.
- The period and init_val inputs are don't-care outside the acceptance cycle.
- The sequencer never asserts cnt_rst outside reset-recovery (see Timing).

## Timing
- Reset values:
  - State is IDLE.
  - Prescaler is 0 and halvings is 0.
  - busy, done, cnt_up, cnt_down, cnt_load, cnt_d are all 0.
  - cnt_rst is 1 while rst is high, and for the first cycle after rst deasserts. This clears the counter.
- Start accepted at edge t:
  - LOAD occupies cycle t+1.
  - cnt_q equals init_val from cycle t+2.
  - RUN begins in cycle t+2.
- One half-life takes period+1 cycles: period RUN cycles plus one STEP cycle.
- The counter reflects the halved value one cycle after STEP.
- done rises the cycle after the final STEP, or the cycle after LOAD when init_val is 0.
- busy falls in the same cycle done falls.
- Mid-run reset forces IDLE immediately (asynchronous). Counter controls drop to 0 except cnt_rst, which behaves as described above.

## Configuration
- HL_LINEAR_EN defined:
  - Adds input port `linear` (1 bit), sampled with start.
  - When the latched value is 1, STEP drives cnt_down=1 instead of cnt_load.
  - The zero check in that case uses cnt_q-1.
  - halvings then counts decrements, still saturating at 15.
- HL_LINEAR_EN undefined:
  - No `linear` port exists.
  - Only halving mode is available and cnt_down is tied to 0.

## Test plan
- Basic decay. Reset, then start with init_val=12, period=3. Required response:
  - cnt_load pulses carry 12, 6, 3, 1, 0.
  - Each half-life is 4 cycles.
  - halvings ends at 4.
  - done pulses once, 18 cycles after start acceptance.
- Zero init. Start with init_val=0 → a single LOAD with cnt_d=0, then done on the next cycle, and halvings=0.
- Period zero. Start with init_val=8, period=0. Required response:
  - Treated as period 1: STEP every 2 cycles.
  - Loads carry 8, 4, 2, 1, 0.
  - halvings reaches 4.
- Start while busy. Pulse start again in the middle of RUN with different values → ignored; the sequence and timing are unchanged.
- Reset mid-run. Assert rst during RUN → state is IDLE immediately, busy=0, cnt_rst=1 for one cycle after release, halvings=0.
- Linear mode (HL_LINEAR_EN only). Start with init_val=3, linear=1, period=2 → cnt_down pulses every 3 cycles, counter reads 3, 2, 1, 0, halvings reaches 3, then done.

Source files
------------

// File: rtl/halflife_sequencer_if.sv
// Control bundle between the half-life sequencer, its user-side start/config
// inputs and the 4-bit counter it drives. HL_LINEAR_EN adds the linear-mode select.
interface halflife_sequencer_if #(
    parameter int N  = 4,
    parameter int PW = 8
);
    logic          start;
    logic [N-1:0]  init_val;
    logic [PW-1:0] period;
`ifdef HL_LINEAR_EN
    logic          linear;
`endif
    logic [N-1:0]  cnt_q;
    logic          cnt_rst;
    logic          cnt_up;
    logic          cnt_down;
    logic          cnt_load;
    logic [N-1:0]  cnt_d;
    logic          busy;
    logic          done;
    logic [3:0]    halvings;

`ifdef HL_LINEAR_EN
    modport master (
        input  start, init_val, period, linear, cnt_q,
        output cnt_rst, cnt_up, cnt_down, cnt_load, cnt_d, busy, done, halvings
    );
    modport slave (
        output start, init_val, period, linear, cnt_q,
        input  cnt_rst, cnt_up, cnt_down, cnt_load, cnt_d, busy, done, halvings
    );
`else
    modport master (
        input  start, init_val, period, cnt_q,
        output cnt_rst, cnt_up, cnt_down, cnt_load, cnt_d, busy, done, halvings
    );
    modport slave (
        output start, init_val, period, cnt_q,
        input  cnt_rst, cnt_up, cnt_down, cnt_load, cnt_d, busy, done, halvings
    );
`endif
endinterface

// File: rtl/halflife_sequencer.sv
// Half-life decay sequencer: loads an initial count, then halves it every period
// cycles until zero. Optional HL_LINEAR_EN adds a decrement-per-period mode.
module halflife_sequencer #(
    parameter int N  = 4,
    parameter int PW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    halflife_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] per_q;
    logic [N-1:0]  ival_q;
    logic [3:0]    halvings_q;
    logic          rst_rec;
    logic          lin_q;
    logic          accept;
    logic          presc_last;
    logic [N-1:0]  half_val;
    logic          step_zero;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [PW-1:0] period_floor(input logic [PW-1:0] p);
        return (p == '0) ? PW'(1) : p;
    endfunction

    assign accept     = (state == S_IDLE) && bus.start;
    assign presc_last = (presc == per_q - PW'(1));
    assign half_val   = bus.cnt_q >> 1;
    assign step_zero  = lin_q ? ((bus.cnt_q - N'(1)) == '0) : (half_val == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = (ival_q == '0) ? S_DONE : S_RUN;
            S_RUN:  if (presc_last) state_nxt = S_STEP;
            S_STEP: state_nxt = step_zero ? S_DONE : S_RUN;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // rst_rec keeps the counter clear for one cycle beyond reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            presc      <= '0;
            halvings_q <= '0;
            rst_rec    <= 1'b1;
        end else begin
            rst_rec <= 1'b0;
            state   <= state_nxt;
            case (state)
                S_IDLE: if (bus.start) begin
                    presc      <= '0;
                    halvings_q <= '0;
                end
                S_RUN:  presc <= presc_last ? '0 : presc + PW'(1);
                S_STEP: halvings_q <= sat_inc4(halvings_q);
                default: ;
            endcase
        end
    end

    // Run configuration is only meaningful once a start has been accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            ival_q <= bus.init_val;
            per_q  <= period_floor(bus.period);
        end
    end

`ifdef HL_LINEAR_EN
    always_ff @(posedge clk) begin
        if (accept) lin_q <= bus.linear;
    end
`else
    assign lin_q = 1'b0;
`endif

    always_comb begin
        bus.cnt_rst  = rst_rec;
        bus.cnt_up   = 1'b0;
        bus.cnt_down = 1'b0;
        bus.cnt_load = 1'b0;
        bus.cnt_d    = '0;
        case (state)
            S_LOAD: begin
                bus.cnt_load = 1'b1;
                bus.cnt_d    = ival_q;
            end
            S_STEP: begin
                if (lin_q) begin
                    bus.cnt_down = 1'b1;
                end else begin
                    bus.cnt_load = 1'b1;
                    bus.cnt_d    = half_val;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.halvings = halvings_q;

endmodule
